// File: rtl/weight_buffer.sv
// Weight line store: 256 x 4096-bit lines, filled by 512-bit loader beats,
// read through a one-cycle-latency request/response port.
module weight_buffer #(
  parameter int LINE_W = 4096,
  parameter int BEAT_W = 512,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_load_start,
  input  logic [7:0]          cfg_load_base,
  input  logic [7:0]          cfg_load_lines,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [BEAT_W-1:0]   ld_data,
  output logic                ld_busy,
  output logic                ld_done,
  input  logic                wbuf_rd_en,
  input  logic [7:0]          wbuf_rd_addr,
  output logic [LINE_W-1:0]   wbuf_rd_data,
  output logic                wbuf_rd_valid
);

  localparam int ASM_W = LINE_W - BEAT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state;
  logic [7:0]        wr_addr;
  logic [8:0]        lines_left;
  logic [2:0]        beat_cnt;
  logic [ASM_W-1:0]  asm_q;
  logic [LINE_W-1:0] mem [DEPTH];

  logic beat_acc;
  logic line_wr;

  assign beat_acc = ld_valid && ld_ready;
  assign line_wr  = beat_acc && (beat_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ld_ready   <= 1'b0;
      ld_busy    <= 1'b0;
      ld_done    <= 1'b0;
      wr_addr    <= 8'd0;
      lines_left <= 9'd0;
      beat_cnt   <= 3'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cfg_load_start) begin
            state      <= S_LOAD;
            ld_ready   <= 1'b1;
            ld_busy    <= 1'b1;
            wr_addr    <= cfg_load_base;
            lines_left <= (cfg_load_lines == 8'd0) ?
                          9'd256 : {1'b0, cfg_load_lines};
            beat_cnt   <= 3'd0;
          end
        end
        S_LOAD: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + 3'd1;
            if (beat_cnt == 3'd7) begin
              wr_addr    <= wr_addr + 8'd1;
              lines_left <= lines_left - 9'd1;
              if (lines_left == 9'd1) begin
                state    <= S_DONE;
                ld_ready <= 1'b0;
                ld_done  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          ld_done <= 1'b0;
          ld_busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
          ld_done  <= 1'b0;
        end
      endcase
    end
  end

  // Beats 0-6 are staged; beat 7 goes straight to memory with them.
  always_ff @(posedge clk) begin
    if (beat_acc && (beat_cnt != 3'd7)) begin
      asm_q[{beat_cnt, 9'd0} +: BEAT_W] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (line_wr) begin
      mem[wr_addr] <= {ld_data, asm_q};
    end
  end

  // Nonblocking read of mem gives read-before-write on a same-line collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_rd_valid <= 1'b0;
      wbuf_rd_data  <= '0;
    end else begin
      wbuf_rd_valid <= wbuf_rd_en;
      if (wbuf_rd_en) begin
        wbuf_rd_data <= mem[wbuf_rd_addr];
      end
    end
  end

endmodule
